// File: rtl/aes_cbc_unchain_if.sv
// Bundles the ciphertext issue, IV load, raw core output and CBC plaintext signals of aes_cbc_unchain.
// Latency: none, this is wiring only.
// Backpressure: none. Producers never stall, so there are no ready signals.
interface aes_cbc_unchain_if #(
    parameter int CNT_W = 16
);
    logic             iv_load;
    logic [127:0]     iv_data;
    logic             ct_valid;
    logic [127:0]     ct_data;
    logic             ct_last;
    logic [127:0]     pt_raw;
    logic             pt_valid;
    logic [127:0]     pt_data;
    logic             pt_last;
    logic [CNT_W-1:0] pt_idx;
    logic             seq_err;
    logic             busy;
`ifdef AES_CBC_PAD_CHECK_EN
    logic [4:0]       pad_len;
    logic             pad_err;

    // Driver side: the IV/ciphertext source plus the decryption core.
    modport master (
        output iv_load, iv_data, ct_valid, ct_data, ct_last, pt_raw,
        input  pt_valid, pt_data, pt_last, pt_idx, seq_err, busy, pad_len, pad_err
    );
    // Unchain block side.
    modport slave (
        input  iv_load, iv_data, ct_valid, ct_data, ct_last, pt_raw,
        output pt_valid, pt_data, pt_last, pt_idx, seq_err, busy, pad_len, pad_err
    );
`else
    // Driver side: the IV/ciphertext source plus the decryption core.
    modport master (
        output iv_load, iv_data, ct_valid, ct_data, ct_last, pt_raw,
        input  pt_valid, pt_data, pt_last, pt_idx, seq_err, busy
    );
    // Unchain block side.
    modport slave (
        input  iv_load, iv_data, ct_valid, ct_data, ct_last, pt_raw,
        output pt_valid, pt_data, pt_last, pt_idx, seq_err, busy
    );
`endif
endinterface

// File: rtl/aes_cbc_unchain.sv
// Turns raw AES-128 ECB decrypt output into CBC plaintext by XORing each block with the previous ciphertext or the IV.
// Latency: PIPE_LAT+1 cycles from ct_valid to pt_valid. The mask rides a PIPE_LAT-deep delay line beside the core.
// Backpressure: none. The core cannot stall. Optional padding check under `AES_CBC_PAD_CHECK_EN.
module aes_cbc_unchain #(
    parameter int PIPE_LAT = 11,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    aes_cbc_unchain_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, STREAM} state_t;

    typedef struct packed {
        logic             vld;
        logic             tag;
        logic [127:0]     mask;
        logic             last;
        logic [CNT_W-1:0] idx;
    } ent_t;

    state_t           state;
    logic [127:0]     chain_reg;
    logic [CNT_W-1:0] issue_cnt;
    logic             seq_err_q;
    ent_t             dl [PIPE_LAT];
    ent_t             push;
    ent_t             tail;
    logic [127:0]     pt_next;
    logic             fire;
    logic             busy_c;

    logic             pt_valid_q;
    logic [127:0]     pt_data_q;
    logic             pt_last_q;
    logic [CNT_W-1:0] pt_idx_q;

    assign tail    = dl[PIPE_LAT-1];
    assign pt_next = bus.pt_raw ^ tail.mask;
    assign fire    = tail.vld && tail.tag;

    // Build the delay-line entry for this cycle.
    // A same-cycle IV load makes the block a first block.
    // A block arriving with no IV held is tagged dead.
    always_comb begin
        push      = '0;
        push.vld  = bus.ct_valid;
        push.tag  = bus.ct_valid && (bus.iv_load || state != IDLE);
        push.mask = bus.iv_load ? bus.iv_data : chain_reg;
        push.last = bus.ct_last;
        push.idx  = bus.iv_load ? '0 : issue_cnt;
    end

    // Message FSM: tracks the chaining value, the block counter and sticky protocol errors.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            chain_reg <= '0;
            issue_cnt <= '0;
            seq_err_q <= 1'b0;
        end else begin
            if ((bus.iv_load && state == STREAM) ||
                (bus.ct_valid && !bus.iv_load && state == IDLE))
                seq_err_q <= 1'b1;
            if (push.tag) begin
                chain_reg <= bus.ct_data;
                issue_cnt <= bus.ct_last ? '0 : push.idx + CNT_W'(1);
                state     <= bus.ct_last ? IDLE : STREAM;
            end else if (bus.iv_load) begin
                chain_reg <= bus.iv_data;
                issue_cnt <= '0;
                state     <= ARMED;
            end
        end
    end

    // Free-running delay line. It stays aligned with the core, which never stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_LAT; i++) dl[i] <= '0;
        end else begin
            dl[0] <= push;
            for (int i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
        end
    end

    // Output register. Data, last and index hold their values between pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pt_valid_q <= 1'b0;
            pt_data_q  <= '0;
            pt_last_q  <= 1'b0;
            pt_idx_q   <= '0;
        end else begin
            pt_valid_q <= fire;
            if (fire) begin
                pt_data_q <= pt_next;
                pt_last_q <= tail.last;
                pt_idx_q  <= tail.idx;
            end
        end
    end

    // Any live entry in the delay line means a block is still in flight.
    always_comb begin
        busy_c = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) busy_c = busy_c | dl[i].vld;
    end

    assign bus.pt_valid = pt_valid_q;
    assign bus.pt_data  = pt_data_q;
    assign bus.pt_last  = pt_last_q;
    assign bus.pt_idx   = pt_idx_q;
    assign bus.seq_err  = seq_err_q;
    assign bus.busy     = busy_c;

`ifdef AES_CBC_PAD_CHECK_EN
    logic [7:0] pad_n;
    logic       pad_ok;
    logic [4:0] pad_len_q;
    logic       pad_err_q;

    // PKCS#7 check on the plaintext about to be registered.
    // The N low bytes must all equal N, with N in 1..16.
    always_comb begin
        pad_n  = pt_next[7:0];
        pad_ok = (pad_n >= 8'd1) && (pad_n <= 8'd16);
        for (int i = 0; i < 16; i++) begin
            if ((8'(i) < pad_n) && (pt_next[i*8 +: 8] != pad_n))
                pad_ok = 1'b0;
        end
    end

    // Padding result is registered alongside the final block and is zero otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pad_len_q <= '0;
            pad_err_q <= 1'b0;
        end else begin
            pad_len_q <= (fire && tail.last && pad_ok) ? pad_n[4:0] : 5'd0;
            pad_err_q <= fire && tail.last && !pad_ok;
        end
    end

    assign bus.pad_len = pad_len_q;
    assign bus.pad_err = pad_err_q;
`endif
endmodule

// File: tb/tb_aes_cbc_unchain.sv
// Directed bench for aes_cbc_unchain. The core is modelled as a PIPE_LAT-cycle delay of a known ECB result.
// Latency: checks the PIPE_LAT+1 issue-to-output latency and back-to-back streaming.
// Backpressure: none. Outputs are collected every cycle they pulse.
module tb_aes_cbc_unchain;
    localparam int PIPE_LAT = 11;
    localparam int CNT_W    = 3;

    localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C0 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C1 = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] C2 = 128'h73bed6b8e3c1743b7116e69e22229516;
    localparam logic [127:0] C3 = 128'h3ff1caa1681fac09120eca307586e1a7;
    localparam logic [127:0] P0 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P1 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] P2 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] P3 = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [127:0] RAW0 = 128'h6bc0bce12a459991e134741a7f9e1925;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] raw;
        logic         last;
        logic [127:0] exp_pt;
        int           exp_idx;
        logic         exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aes_cbc_unchain_if #(.CNT_W(CNT_W)) bus ();
    aes_cbc_unchain #(.PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Core model: the raw ECB result shows up PIPE_LAT cycles after issue.
    logic [127:0] raw_in;
    logic [127:0] rp [PIPE_LAT];
    always @(posedge clk) begin
        rp[0] <= raw_in;
        for (int i = 1; i < PIPE_LAT; i++) rp[i] <= rp[i-1];
    end
    assign bus.pt_raw = rp[PIPE_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] o_data [$];
    logic         o_last [$];
    int           o_idx  [$];
    int           o_cyc  [$];
    logic [4:0]   o_plen [$];
    logic         o_perr [$];

    // Collect every output pulse away from the active edge.
    always @(negedge clk) begin
        if (bus.pt_valid === 1'b1) begin
            o_data.push_back(bus.pt_data);
            o_last.push_back(bus.pt_last);
            o_idx.push_back(int'(bus.pt_idx));
            o_cyc.push_back(cyc);
`ifdef AES_CBC_PAD_CHECK_EN
            o_plen.push_back(bus.pad_len);
            o_perr.push_back(bus.pad_err);
`endif
        end
    end

    int nchk = 0;
    int nerr = 0;
    int last_issue = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.iv_load  = 1'b0;
        bus.iv_data  = '0;
        bus.ct_valid = 1'b0;
        bus.ct_data  = '0;
        bus.ct_last  = 1'b0;
        raw_in       = '0;
    endtask

    task automatic drive(input logic ivl, input logic [127:0] ivd, input logic ctv,
                         input logic [127:0] ctd, input logic lst, input logic [127:0] raw);
        bus.iv_load  = ivl;
        bus.iv_data  = ivd;
        bus.ct_valid = ctv;
        bus.ct_data  = ctd;
        bus.ct_last  = lst;
        raw_in       = raw;
        last_issue   = cyc;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        o_data.delete(); o_last.delete(); o_idx.delete();
        o_cyc.delete(); o_plen.delete(); o_perr.delete();
    endtask

    vec_t tbl [4];

    initial begin
        int iss;
        logic [127:0] ct_w;
        logic [127:0] exp_w;

        tbl[0] = '{C0, P0 ^ IV, 1'b0, P0, 0, 1'b0};
        tbl[1] = '{C1, P1 ^ C0, 1'b0, P1, 1, 1'b0};
        tbl[2] = '{C2, P2 ^ C1, 1'b0, P2, 2, 1'b0};
        tbl[3] = '{C3, P3 ^ C2, 1'b1, P3, 3, 1'b1};

        idle();
        rst = 1'b0;
        wait_cycles(3);
        chk("rst_pt_valid", bus.pt_valid, 0);
        chk("rst_pt_data", bus.pt_data, 0);
        chk("rst_pt_last", bus.pt_last, 0);
        chk("rst_pt_idx", bus.pt_idx, 0);
        chk("rst_seq_err", bus.seq_err, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b1;
        wait_cycles(1);

        // Single-block message using the NIST first block.
        clear_q();
        drive(1, IV, 0, 0, 0, 0);
        drive(0, 0, 1, C0, 1, RAW0);
        iss = last_issue;
        wait_cycles(20);
        chk("single_count", o_data.size(), 1);
        if (o_data.size() >= 1) begin
            chk("single_data", o_data[0], P0);
            chk("single_last", o_last[0], 1);
            chk("single_idx", o_idx[0], 0);
            chk("single_latency", o_cyc[0] - iss, PIPE_LAT + 1);
        end

        // IV reload from ARMED together with the first block.
        clear_q();
        drive(1, IV, 0, 0, 0, 0);
        drive(1, {128{1'b1}}, 1, C1, 1, 128'h0123456789abcdef0011223344556677);
        wait_cycles(20);
        chk("ivsame_count", o_data.size(), 1);
        if (o_data.size() >= 1) begin
            chk("ivsame_data", o_data[0], 128'hfedcba9876543210ffeeddccbbaa9988);
            chk("ivsame_idx", o_idx[0], 0);
        end
        chk("ivsame_no_err", bus.seq_err, 0);

        // A 9-block message wraps the 3-bit index counter.
        // With raw 0 the output equals the mask.
        clear_q();
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            ct_w = {16{8'(i + 1)}};
            drive(0, 0, 1, ct_w, (i == 8), 0);
        end
        wait_cycles(20);
        chk("wrap_count", o_data.size(), 9);
        for (int j = 0; j < 9 && j < o_data.size(); j++) begin
            exp_w = (j == 0) ? 128'h0 : {16{8'(j)}};
            chk($sformatf("wrap_data%0d", j), o_data[j], exp_w);
            chk($sformatf("wrap_idx%0d", j), o_idx[j], j % 8);
            chk($sformatf("wrap_last%0d", j), o_last[j], (j == 8));
        end
        chk("wrap_no_err", bus.seq_err, 0);

        // An IV load mid-message flags an error and restarts the index.
        clear_q();
        drive(1, IV, 0, 0, 0, 0);
        drive(0, 0, 1, C0, 0, RAW0);
        drive(1, IV, 0, 0, 0, 0);
        drive(0, 0, 1, C0, 1, RAW0);
        wait_cycles(20);
        chk("midiv_seq_err", bus.seq_err, 1);
        chk("midiv_count", o_data.size(), 2);
        if (o_data.size() >= 2) begin
            chk("midiv_last0", o_last[0], 0);
            chk("midiv_data1", o_data[1], P0);
            chk("midiv_idx1", o_idx[1], 0);
            chk("midiv_last1", o_last[1], 1);
        end

        // Reset with three blocks in flight discards them.
        drive(1, IV, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, tbl[i].ct, 0, tbl[i].raw);
        wait_cycles(3);
        clear_q();
        rst = 1'b0;
        wait_cycles(1);
        chk("flush_pt_valid", bus.pt_valid, 0);
        chk("flush_pt_data", bus.pt_data, 0);
        chk("flush_pt_last", bus.pt_last, 0);
        chk("flush_pt_idx", bus.pt_idx, 0);
        chk("flush_seq_err", bus.seq_err, 0);
        chk("flush_busy", bus.busy, 0);
        rst = 1'b1;
        wait_cycles(20);
        chk("flush_no_output", o_data.size(), 0);

        // Ciphertext with no IV held is an error and produces no output.
        clear_q();
        drive(0, 0, 1, C0, 1, RAW0);
        wait_cycles(20);
        chk("noiv_seq_err", bus.seq_err, 1);
        chk("noiv_no_output", o_data.size(), 0);

        // Four-block NIST message, issued back to back.
        clear_q();
        drive(1, IV, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, tbl[i].ct, tbl[i].last, tbl[i].raw);
        iss = last_issue;
        repeat (iss + PIPE_LAT - cyc) @(posedge clk);
        @(negedge clk);
        chk("stream_busy_hi", bus.busy, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stream_busy_lo", bus.busy, 0);
        wait_cycles(5);
        chk("stream_count", o_data.size(), 4);
        for (int i = 0; i < 4 && i < o_data.size(); i++) begin
            chk($sformatf("stream_data%0d", i), o_data[i], tbl[i].exp_pt);
            chk($sformatf("stream_idx%0d", i), o_idx[i], tbl[i].exp_idx);
            chk($sformatf("stream_last%0d", i), o_last[i], tbl[i].exp_last);
            chk($sformatf("stream_gap%0d", i), o_cyc[i] - o_cyc[0], i);
        end

`ifdef AES_CBC_PAD_CHECK_EN
        begin
            logic [127:0] pad_pt  [3];
            logic [4:0]   pad_len [3];
            logic         pad_err [3];
            pad_pt[0] = 128'h00112233445566778899aabb04040404; pad_len[0] = 5'd4; pad_err[0] = 1'b0;
            pad_pt[1] = 128'h00112233445566778899aabb05040404; pad_len[1] = 5'd0; pad_err[1] = 1'b1;
            pad_pt[2] = 128'h00112233445566778899aabbccddee00; pad_len[2] = 5'd0; pad_err[2] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                clear_q();
                drive(1, 0, 0, 0, 0, 0);
                drive(0, 0, 1, C0, 1, pad_pt[k]);
                wait_cycles(20);
                chk($sformatf("pad_count%0d", k), o_data.size(), 1);
                if (o_data.size() >= 1) begin
                    chk($sformatf("pad_len%0d", k), o_plen[0], pad_len[k]);
                    chk($sformatf("pad_err%0d", k), o_perr[0], pad_err[k]);
                end
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
